wb_arbiter: RTL and testbench

- Write-back arbiter for the multiported register file.
- Collects results from NSRC execution units over valid/ready handshakes and buffers one result per unit.
- Each cycle it grants up to WRITE_PORTS results, round-robin, and drives registered wr_addr/wr_enable/wr_data outputs straight into the register file write ports.
- Guarantees that no two write ports target the same register in one cycle, and discards writes to register 0.

---
 rtl/wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers one result per execution unit and issues up to
// WRITE_PORTS conflict-free register-file writes per cycle, round-robin.
module wb_arbiter #(
  parameter int unsigned NSRC        = 6,
  parameter int unsigned WRITE_PORTS = 4,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NSRC-1:0]                   src_valid,
  output logic [NSRC-1:0]                   src_ready,
  input  logic [NSRC*ADDR_WIDTH-1:0]        src_addr,
  input  logic [NSRC*DATA_WIDTH-1:0]        src_data,
  input  logic                              flush,
  output logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
  output logic [WRITE_PORTS-1:0]            wr_enable,
  output logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic                              busy
);

  localparam int unsigned PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]        hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0]  hold_addr_q [NSRC];
  logic [ADDR_WIDTH-1:0]  hold_addr_d [NSRC];
  logic [DATA_WIDTH-1:0]  hold_data_q [NSRC];
  logic [DATA_WIDTH-1:0]  hold_data_d [NSRC];
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [WRITE_PORTS-1:0] wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  wr_data_q [WRITE_PORTS];

  logic [ADDR_WIDTH-1:0]  in_addr [NSRC];
  logic [DATA_WIDTH-1:0]  in_data [NSRC];

  logic [NSRC-1:0]        grant;
  logic [WRITE_PORTS-1:0] gnt_used;
  logic [ADDR_WIDTH-1:0]  gnt_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  gnt_data [WRITE_PORTS];
  logic [PTR_W-1:0]       last_src;
  logic                   any_grant;

  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      in_addr[i] = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      in_data[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan from rr_ptr; the k-th accepted entry lands on port k. Entries whose
  // address is already claimed this cycle are skipped and stay pending.
  always_comb begin
    int unsigned           idx;
    int unsigned           n;
    logic                  cur_v;
    logic                  conflict;
    logic [ADDR_WIDTH-1:0] cur_a;
    logic [DATA_WIDTH-1:0] cur_d;
    grant     = '0;
    gnt_used  = '0;
    last_src  = rr_ptr_q;
    any_grant = 1'b0;
    n         = 0;
    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
      gnt_addr[p] = '0;
      gnt_data[p] = '0;
    end
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx      = (32'(rr_ptr_q) + k) % NSRC;
      cur_v    = 1'b0;
      cur_a    = '0;
      cur_d    = '0;
      conflict = 1'b0;
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (s == idx) begin
          cur_v = hold_valid_q[s];
          cur_a = hold_addr_q[s];
          cur_d = hold_data_q[s];
        end
      end
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
        if (gnt_used[p] && (gnt_addr[p] == cur_a)) conflict = 1'b1;
      end
      if (cur_v && !conflict && (n < WRITE_PORTS)) begin
        for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
          if (p == n) begin
            gnt_used[p] = 1'b1;
            gnt_addr[p] = cur_a;
            gnt_data[p] = cur_d;
          end
        end
        for (int unsigned s = 0; s < NSRC; s++) begin
          if (s == idx) grant[s] = 1'b1;
        end
        last_src  = PTR_W'(idx);
        any_grant = 1'b1;
        n         = n + 1;
      end
    end
  end

  assign src_ready = {NSRC{~flush}} & (~hold_valid_q | grant);

  // A reload takes priority over the grant clear; address 0 is consumed
  // without ever becoming a pending write.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (flush) begin
        hold_valid_d[i] = 1'b0;
      end else if (src_valid[i] && src_ready[i]) begin
        hold_valid_d[i] = (in_addr[i] != '0);
        hold_addr_d[i]  = in_addr[i];
        hold_data_d[i]  = in_data[i];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!flush && any_grant) begin
      rr_ptr_d = (last_src == PTR_W'(NSRC - 1)) ? '0 : last_src + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      wr_en_q      <= '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
        hold_addr_q[i] <= '0;
        hold_data_q[i] <= '0;
      end
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
        wr_addr_q[p] <= '0;
        wr_data_q[p] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
      if (flush) begin
        wr_en_q <= '0;
      end else begin
        wr_en_q <= gnt_used;
        for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
          if (gnt_used[p]) begin
            wr_addr_q[p] <= gnt_addr[p];
            wr_data_q[p] <= gnt_data[p];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
      wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr_q[p];
      wr_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_q[p];
    end
  end

  assign wr_enable = wr_en_q;
  assign busy      = (|hold_valid_q) | (|wr_en_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, round-robin fill, address conflict,
// r0 discard, flush and single-source streaming.
module tb_wb_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [5:0]   src_valid;
  logic [5:0]   src_ready;
  logic [29:0]  src_addr;
  logic [191:0] src_data;
  logic         flush;
  logic [19:0]  wr_addr;
  logic [3:0]   wr_enable;
  logic [127:0] wr_data;
  logic         busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  wb_arbiter #(
    .NSRC       (6),
    .WRITE_PORTS(4),
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_addr (src_addr),
    .src_data (src_data),
    .flush    (flush),
    .wr_addr  (wr_addr),
    .wr_enable(wr_enable),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [19:0] pa(input logic [4:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] pd(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic set_src(input int unsigned i, input logic [4:0] a, input logic [31:0] d);
    src_valid[i]         = 1'b1;
    src_addr[i*5 +: 5]   = a;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    for (int unsigned i = 0; i < 6; i++) set_src(i, 5'(i + 1), 32'(32'h100 + i));
    #22;
    reset_n = 1'b1;
    #1;
    check("rst_wr_en", 128'(wr_enable), 128'(4'b0000));
    check("rst_ready", 128'(src_ready), 128'(6'b111111));
    check("rst_busy",  128'(busy), 128'(1'b0));
    check("rst_addr",  128'(wr_addr), 128'(0));

    // Round-robin fill, all six sources on distinct addresses
    tick();
    check("rr_e0_en",   128'(wr_enable), 128'(4'b0000));
    check("rr_e0_busy", 128'(busy), 128'(1'b1));
    check("rr_e0_rdy",  128'(src_ready), 128'(6'b001111));
    tick();
    check("rr_e1_en",   128'(wr_enable), 128'(4'b1111));
    check("rr_e1_addr", 128'(wr_addr), 128'(pa(1, 2, 3, 4)));
    check("rr_e1_data", wr_data, pd(32'h100, 32'h101, 32'h102, 32'h103));
    idle();
    tick();
    check("rr_e2_en",   128'(wr_enable), 128'(4'b1111));
    check("rr_e2_addr", 128'(wr_addr), 128'(pa(5, 6, 1, 2)));
    check("rr_e2_data", wr_data, pd(32'h104, 32'h105, 32'h100, 32'h101));
    tick();
    check("rr_e3_en",   128'(wr_enable), 128'(4'b0011));
    check("rr_e3_addr", 128'(wr_addr), 128'(pa(3, 4, 1, 2)));
    tick();
    check("rr_e4_en",   128'(wr_enable), 128'(4'b0000));
    check("rr_e4_busy", 128'(busy), 128'(1'b0));

    // Two sources racing for r7
    do_reset();
    set_src(1, 5'd7, 32'hAAAA);
    set_src(2, 5'd7, 32'hBBBB);
    #1;
    check("cf_ready", 128'(src_ready), 128'(6'b111111));
    tick();
    idle();
    tick();
    check("cf_e1_en",   128'(wr_enable), 128'(4'b0001));
    check("cf_e1_addr", 128'(wr_addr[4:0]), 128'(5'd7));
    check("cf_e1_data", 128'(wr_data[31:0]), 128'(32'hAAAA));
    tick();
    check("cf_e2_en",   128'(wr_enable), 128'(4'b0001));
    check("cf_e2_addr", 128'(wr_addr[4:0]), 128'(5'd7));
    check("cf_e2_data", 128'(wr_data[31:0]), 128'(32'hBBBB));
    tick();
    check("cf_e3_en",   128'(wr_enable), 128'(4'b0000));
    check("cf_e3_busy", 128'(busy), 128'(1'b0));

    // Write to r0 is accepted and dropped
    do_reset();
    set_src(3, 5'd0, 32'hDEAD);
    #1;
    check("r0_ready", 128'(src_ready[3]), 128'(1'b1));
    tick();
    idle();
    check("r0_e0_busy", 128'(busy), 128'(1'b0));
    check("r0_e0_en",   128'(wr_enable), 128'(4'b0000));
    tick();
    check("r0_e1_en",   128'(wr_enable), 128'(4'b0000));
    check("r0_e1_busy", 128'(busy), 128'(1'b0));

    // Flush with entries pending and one write already registered
    do_reset();
    set_src(1, 5'd11, 32'h11);
    tick();
    idle();
    set_src(0, 5'd9, 32'h9);
    set_src(2, 5'd10, 32'h10);
    tick();
    check("fl_pre_en",   128'(wr_enable), 128'(4'b0001));
    check("fl_pre_addr", 128'(wr_addr[4:0]), 128'(5'd11));
    idle();
    flush = 1'b1;
    set_src(0, 5'd9, 32'h99);
    #1;
    check("fl_ready", 128'(src_ready), 128'(6'b000000));
    check("fl_busy",  128'(busy), 128'(1'b1));
    tick();
    idle();
    check("fl_post_en",   128'(wr_enable), 128'(4'b0000));
    check("fl_post_busy", 128'(busy), 128'(1'b0));
    check("fl_post_addr", 128'(wr_addr[4:0]), 128'(5'd11));
    tick();
    check("fl_idle_en", 128'(wr_enable), 128'(4'b0000));

    // Single source streaming addrs 1..8
    do_reset();
    for (int unsigned k = 0; k < 8; k++) begin
      set_src(0, 5'(k + 1), 32'(32'h50 + k));
      #1;
      check("st_ready", 128'(src_ready[0]), 128'(1'b1));
      tick();
      if (k >= 1) begin
        check("st_en",   128'(wr_enable), 128'(4'b0001));
        check("st_addr", 128'(wr_addr[4:0]), 128'(k));
      end
    end
    idle();
    tick();
    check("st_last_en",   128'(wr_enable), 128'(4'b0001));
    check("st_last_addr", 128'(wr_addr[4:0]), 128'(5'd8));
    check("st_last_data", 128'(wr_data[31:0]), 128'(32'h57));
    tick();
    check("st_done_en",   128'(wr_enable), 128'(4'b0000));
    check("st_done_busy", 128'(busy), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
